// File: rtl/alu_param_seq.sv
// alu_param_seq: parametrised, handshaked ALU with registered results and
// status flags. MOD uses an iterative restoring divider that produces one
// quotient bit per cycle; only the remainder is kept.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   reset        synchronous, active-high
//   in_valid     operand/op bundle valid
//   in_ready     block can accept a bundle this cycle (idle and not in reset)
//   a, b         operands, WIDTH bits
//   aluOp        000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD
//   c_in         carry-in, used by ADD only
//   out_valid    result bundle valid
//   out_ready    consumer takes the result this cycle
//   result       operation result, WIDTH bits
//   c_out        ADD: carry out; SUB: 1 = no borrow; otherwise 0
//   overflow     signed overflow for ADD/SUB; otherwise 0
//   zero         result == 0
//   div_by_zero  MOD issued with b == 0
module alu_param_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SLT_SIGN = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluOp,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_SLT = 3'b100,
    OP_ADD = 3'b101,
    OP_SUB = 3'b110,
    OP_MOD = 3'b111
  } op_t;

  state_t          state;
  op_t             op_in;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic             lt;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] rem_next;

  assign op_in    = op_t'(aluOp);
  // Gated by reset so the block never advertises readiness while resetting.
  assign in_ready = (state == IDLE) && !reset;

  // Single-cycle datapath, evaluated on the live inputs in the accept cycle.
  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    diff     = a - b;
    if (SLT_SIGN) lt = ($signed(a) < $signed(b));
    else          lt = (a < b);
    case (op_in)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_ADD: begin
        alu_res  = sum_ext[WIDTH-1:0];
        alu_cout = sum_ext[WIDTH];
        alu_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res  = diff;
        alu_cout = (a >= b);
        alu_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // Only reached as a result when b == 0: the remainder is a itself.
      OP_MOD: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  // One restoring-division step. The shifted remainder is one bit wider so
  // the compare against the divisor can never wrap.
  always_comb begin
    rem_shift = {rem, dividend[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    if (rem_shift >= {1'b0, divisor}) rem_next = rem_diff[WIDTH-1:0];
    else                              rem_next = rem_shift[WIDTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      c_out       <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      rem         <= '0;
      dividend    <= '0;
      divisor     <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op_in == OP_MOD && b != '0) begin
              rem      <= '0;
              dividend <= a;
              divisor  <= b;
              count    <= CW'(WIDTH - 1);
              state    <= CALC;
            end else begin
              result      <= alu_res;
              c_out       <= alu_cout;
              overflow    <= alu_ovf;
              zero        <= (alu_res == '0);
              div_by_zero <= (op_in == OP_MOD);
              out_valid   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        CALC: begin
          rem      <= rem_next;
          dividend <= {dividend[WIDTH-2:0], 1'b0};
          count    <= count - CW'(1);
          if (count == '0) begin
            result      <= rem_next;
            c_out       <= 1'b0;
            overflow    <= 1'b0;
            zero        <= (rem_next == '0);
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_param_seq.sv
// Self-checking bench for alu_param_seq: a 32-bit instance driven from a
// table of hand-computed vectors, plus two 8-bit instances (signed and
// unsigned SLT) and hand-written reset / hold sequences.
module tb_alu_param_seq;

  logic        CLK = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [31:0] a, b;
  logic [2:0]  aluOp;
  logic        c_in;
  logic        in_ready, out_valid, c_out, overflow, zero, div_by_zero;
  logic [31:0] result;

  logic        in_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic        in_ready8s, out_valid8s, c_out8s, overflow8s, zero8s, dbz8s;
  logic [7:0]  result8s;
  logic        in_ready8u, out_valid8u, c_out8u, overflow8u, zero8u, dbz8u;
  logic [7:0]  result8u;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_param_seq #(.WIDTH(32), .SLT_SIGN(1'b1)) dut32 (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluOp(aluOp), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c_out(c_out), .overflow(overflow), .zero(zero), .div_by_zero(div_by_zero)
  );

  alu_param_seq #(.WIDTH(8), .SLT_SIGN(1'b1)) dut8s (
    .CLK(CLK), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8s),
    .a(a8), .b(b8), .aluOp(op8), .c_in(1'b0),
    .out_valid(out_valid8s), .out_ready(out_ready8), .result(result8s),
    .c_out(c_out8s), .overflow(overflow8s), .zero(zero8s), .div_by_zero(dbz8s)
  );

  alu_param_seq #(.WIDTH(8), .SLT_SIGN(1'b0)) dut8u (
    .CLK(CLK), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8u),
    .a(a8), .b(b8), .aluOp(op8), .c_in(1'b0),
    .out_valid(out_valid8u), .out_ready(out_ready8), .result(result8u),
    .c_out(c_out8u), .overflow(overflow8u), .zero(zero8u), .div_by_zero(dbz8u)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        z;
    logic        dz;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one bundle at a falling edge in IDLE, wait for the result while
  // throwing junk at the inputs, check it, hold it, then drain it.
  task automatic run_vec(input vec_t v, input int hold);
    int lat;
    int exp_lat;
    logic busy_ok;
    exp_lat = (v.op == 3'd7 && v.b != 32'd0) ? 33 : 1;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = v.a; b = v.b; aluOp = v.op; c_in = v.cin; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    @(negedge CLK);
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      a = $urandom; b = $urandom; aluOp = 3'($urandom); c_in = 1'($urandom);
      in_valid = 1'b1;
      @(negedge CLK);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("busy_no_ready", {31'd0, busy_ok}, 32'd1);
    check("result", result, v.res);
    check("flags", {28'd0, c_out, overflow, zero, div_by_zero},
          {28'd0, v.co, v.ov, v.z, v.dz});
    for (int i = 0; i < hold; i++) begin
      a = $urandom; b = $urandom; aluOp = 3'($urandom); in_valid = 1'b1;
      @(negedge CLK);
      check("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
      check("hold_result", result, v.res);
      check("hold_flags", {28'd0, c_out, overflow, zero, div_by_zero},
            {28'd0, v.co, v.ov, v.z, v.dz});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    @(negedge CLK);
    check("drain_valid_ready", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic run_slt8(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] exp_s, input logic [7:0] exp_u);
    a8 = va; b8 = vb; op8 = 3'd4; in_valid8 = 1'b1;
    @(posedge CLK); #1;
    in_valid8 = 1'b0;
    @(negedge CLK);
    check("slt8_valid", {30'd0, out_valid8s, out_valid8u}, 32'd3);
    check("slt8_signed", {24'd0, result8s}, {24'd0, exp_s});
    check("slt8_unsigned", {24'd0, result8u}, {24'd0, exp_u});
    out_ready8 = 1'b1;
    @(posedge CLK); #1;
    out_ready8 = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    //          op     a             b             cin   res           co    ov    z     dz
    vecs[0]  = '{3'd5, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'd5, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'd6, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd7, 32'd100,      32'd7,        1'b0, 32'd2,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd7, 32'h00001234, 32'h00000000, 1'b0, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'd0, 32'hF0F01234, 32'h0FF0FFFF, 1'b0, 32'h00F01234, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd1, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'd2, 32'hA5A5A5A5, 32'hFFFF0000, 1'b0, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd3, 32'h0F0F0000, 32'h00F000FF, 1'b0, 32'hF000FF00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd4, 32'h80000000, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd4, 32'h00000005, 32'h00000003, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'd5, 32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'd5, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{3'd6, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{3'd6, 32'h00000007, 32'h00000007, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{3'd7, 32'hFFFFFFFF, 32'h0000000A, 1'b0, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{3'd7, 32'd21,       32'd7,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; aluOp = '0; c_in = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_reset_result", result, 32'd0);
    check("post_reset_outs", {27'd0, out_valid, c_out, overflow, zero, div_by_zero}, 32'd0);
    @(negedge CLK);

    // First vector held for 5 cycles in DONE; the rest briefly.
    for (int i = 0; i < 18; i++) run_vec(vecs[i], (i == 0) ? 5 : 1);

    // Reset ten cycles into a MOD: everything back to reset values.
    check("pre_reset_result_nonzero", {31'd0, result != 32'd0}, 32'd1);
    a = 32'd100; b = 32'd7; aluOp = 3'd7; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge CLK);
    check("calc_busy", {30'd0, out_valid, in_ready}, 32'd0);
    reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_result", result, 32'd0);
    check("abort_outs", {26'd0, out_valid, c_out, overflow, zero, div_by_zero, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    run_vec('{3'd5, 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0}, 1);
    run_vec('{3'd7, 32'd100, 32'd7, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0}, 0);

    // 8-bit SLT: signed and unsigned interpretation side by side.
    run_slt8(8'h80, 8'h01, 8'h01, 8'h00);
    run_slt8(8'h01, 8'h80, 8'h00, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
